// File: rtl/raw10_unpacker.sv
// CSI-2 RAW10 payload unpacker: 4-byte beats in, groups of 4 x 10-bit pixels out.
// Tracks word_count so short final beats and truncated or over-long packets end deterministically.
module raw10_unpacker #(
  parameter logic [5:0] DATA_TYPE       = 6'h2B,
  parameter bit         MATCH_CHANNEL   = 1'b0,
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             interrupt,
  input  logic [1:0]       virtual_channel,
  input  logic [5:0]       image_data_type,
  input  logic [15:0]      word_count,
  input  logic [3:0][7:0]  image_data,
  input  logic             image_data_enable,
  output logic [3:0][9:0]  pixel,
  output logic             pixel_enable,
  output logic             length_error
);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_END} state_t;

  state_t           state_reg, state_next;
  logic             interrupt_q_reg;
  logic [15:0]      remaining_reg, remaining_next;
  logic [3:0]       buf_count_reg, buf_count_next;
  logic [3:0][7:0]  buf_reg, buf_next;
  logic [3:0][9:0]  pixel_reg, pixel_next;
  logic             pixel_enable_reg, pixel_enable_next;
  logic             length_error_reg, length_error_next;

  logic             start;
  logic             accept;
  logic [2:0]       take;
  logic [3:0]       total;
  logic [3:0]       count_after;
  logic [15:0]      remaining_after;
  logic [7:0][7:0]  merged;
  logic [3:0][9:0]  group;

  assign start  = interrupt & ~interrupt_q_reg;
  assign accept = (image_data_type == DATA_TYPE) &&
                  (!MATCH_CHANNEL || (virtual_channel == VIRTUAL_CHANNEL));

  // Only the first min(4, remaining) bytes of a beat belong to the payload.
  assign take            = (remaining_reg >= 16'd4) ? 3'd4 : remaining_reg[2:0];
  assign total           = buf_count_reg + {1'b0, take};
  assign count_after     = (total >= 4'd5) ? (total - 4'd5) : total;
  assign remaining_after = remaining_reg - {13'd0, take};

  // merged = buffered bytes followed by the new beat, oldest byte at index 0.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      logic [3:0] rel;
      logic [7:0] beat_byte;
      assign rel       = 4'(gi) - buf_count_reg;
      assign beat_byte = (rel < 4'd4) ? image_data[rel[1:0]] : 8'h00;
      if (gi < 4) begin : g_buf
        assign merged[gi] = (4'(gi) < buf_count_reg) ? buf_reg[gi] : beat_byte;
      end else begin : g_new
        assign merged[gi] = beat_byte;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_pix
      assign group[gi] = {merged[gi], merged[4][2*gi+1 -: 2]};
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    remaining_next    = remaining_reg;
    buf_count_next    = buf_count_reg;
    buf_next          = buf_reg;
    pixel_next        = pixel_reg;
    pixel_enable_next = 1'b0;
    length_error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (accept && (word_count != 16'd0)) begin
            state_next     = ACTIVE;
            remaining_next = word_count;
            buf_count_next = 4'd0;
          end else begin
            state_next = WAIT_END;
          end
        end
      end
      ACTIVE: begin
        if (!interrupt) begin
          state_next        = IDLE;
          buf_count_next    = 4'd0;
          length_error_next = 1'b1;
        end else if (image_data_enable) begin
          remaining_next = remaining_after;
          buf_count_next = count_after;
          if (total >= 4'd5) begin
            pixel_next        = group;
            pixel_enable_next = 1'b1;
            buf_next          = {8'h00, merged[7], merged[6], merged[5]};
          end else begin
            buf_next = merged[3:0];
          end
          if (remaining_after == 16'd0) begin
            state_next        = WAIT_END;
            length_error_next = (count_after != 4'd0);
          end
        end
      end
      WAIT_END: begin
        if (!interrupt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // interrupt_q resets high so a packet already in flight is not seen as a new start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      interrupt_q_reg  <= 1'b1;
      remaining_reg    <= 16'd0;
      buf_count_reg    <= 4'd0;
      buf_reg          <= '0;
      pixel_reg        <= '0;
      pixel_enable_reg <= 1'b0;
      length_error_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      interrupt_q_reg  <= interrupt;
      remaining_reg    <= remaining_next;
      buf_count_reg    <= buf_count_next;
      buf_reg          <= buf_next;
      pixel_reg        <= pixel_next;
      pixel_enable_reg <= pixel_enable_next;
      length_error_reg <= length_error_next;
    end
  end

  assign pixel        = pixel_reg;
  assign pixel_enable = pixel_enable_reg;
  assign length_error = length_error_reg;

endmodule

// File: tb/tb_raw10_unpacker.sv
// Directed bench for raw10_unpacker: hand-computed pixel groups and error pulses.
module tb_raw10_unpacker;

  logic             clock = 1'b0;
  logic             reset;
  logic             interrupt;
  logic [1:0]       virtual_channel;
  logic [5:0]       image_data_type;
  logic [15:0]      word_count;
  logic [3:0][7:0]  image_data;
  logic             image_data_enable;
  logic [3:0][9:0]  pixel;
  logic             pixel_enable;
  logic             length_error;

  int total = 0;
  int bad   = 0;

  raw10_unpacker dut (
    .clock             (clock),
    .reset             (reset),
    .interrupt         (interrupt),
    .virtual_channel   (virtual_channel),
    .image_data_type   (image_data_type),
    .word_count        (word_count),
    .image_data        (image_data),
    .image_data_enable (image_data_enable),
    .pixel             (pixel),
    .pixel_enable      (pixel_enable),
    .length_error      (length_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_pkt(input logic [5:0] dt, input logic [15:0] wc);
    interrupt         = 1'b1;
    image_data_type   = dt;
    word_count        = wc;
    image_data_enable = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [31:0] data);
    image_data        = data;
    image_data_enable = 1'b1;
    tick();
  endtask

  task automatic end_pkt();
    image_data_enable = 1'b0;
    interrupt         = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; interrupt = 1'b0; virtual_channel = 2'd0;
    image_data_type = 6'h00; word_count = 16'd0;
    image_data = '0; image_data_enable = 1'b0;
    tick(); tick();
    check("rst_pe",  {39'd0, pixel_enable}, 40'd0);
    check("rst_le",  {39'd0, length_error}, 40'd0);
    check("rst_pix", pixel, 40'd0);
    reset = 1'b0;
    tick();

    // 1: single group, second beat carries one payload byte
    start_pkt(6'h2B, 16'd5);
    beat({8'h78, 8'h56, 8'h34, 8'h12});
    check("t1_pe_b1", {39'd0, pixel_enable}, 40'd0);
    beat({8'hAA, 8'hBB, 8'hCC, 8'hE4});
    check("t1_pe",  {39'd0, pixel_enable}, 40'd1);
    check("t1_pix", pixel, {10'h1E3, 10'h15A, 10'h0D1, 10'h048});
    check("t1_le",  {39'd0, length_error}, 40'd0);
    end_pkt();
    check("t1_pe_off", {39'd0, pixel_enable}, 40'd0);
    check("t1_le_off", {39'd0, length_error}, 40'd0);

    // 2: wc=20, bytes 00..13 back-to-back
    start_pkt(6'h2B, 16'd20);
    beat({8'h03, 8'h02, 8'h01, 8'h00});
    check("t2_pe_b1", {39'd0, pixel_enable}, 40'd0);
    beat({8'h07, 8'h06, 8'h05, 8'h04});
    check("t2_pe_b2", {39'd0, pixel_enable}, 40'd1);
    check("t2_pix0", pixel, {10'h00C, 10'h008, 10'h005, 10'h000});
    beat({8'h0B, 8'h0A, 8'h09, 8'h08});
    check("t2_pe_b3", {39'd0, pixel_enable}, 40'd1);
    check("t2_pix1", pixel, {10'h020, 10'h01C, 10'h01A, 10'h015});
    beat({8'h0F, 8'h0E, 8'h0D, 8'h0C});
    check("t2_pe_b4", {39'd0, pixel_enable}, 40'd1);
    check("t2_pix2", pixel, {10'h034, 10'h030, 10'h02F, 10'h02A});
    beat({8'h13, 8'h12, 8'h11, 8'h10});
    check("t2_pe_b5", {39'd0, pixel_enable}, 40'd1);
    check("t2_pix3", pixel, {10'h048, 10'h045, 10'h040, 10'h03F});
    check("t2_le", {39'd0, length_error}, 40'd0);
    end_pkt();
    check("t2_pe_off", {39'd0, pixel_enable}, 40'd0);
    check("t2_le_off", {39'd0, length_error}, 40'd0);

    // 3: non-RAW10 packet is ignored
    start_pkt(6'h18, 16'd8);
    beat({8'h78, 8'h56, 8'h34, 8'h12});
    check("t3_pe_b1", {39'd0, pixel_enable}, 40'd0);
    beat({8'hFF, 8'hFF, 8'hFF, 8'hE4});
    check("t3_pe_b2", {39'd0, pixel_enable}, 40'd0);
    check("t3_le_b2", {39'd0, length_error}, 40'd0);
    end_pkt();
    check("t3_le_end", {39'd0, length_error}, 40'd0);

    // 4: wc=7 leaves two bytes over; error coincides with the group
    start_pkt(6'h2B, 16'd7);
    beat({8'h78, 8'h56, 8'h34, 8'h12});
    beat({8'hDD, 8'hBC, 8'h9A, 8'hE4});
    check("t4_pe",  {39'd0, pixel_enable}, 40'd1);
    check("t4_pix", pixel, {10'h1E3, 10'h15A, 10'h0D1, 10'h048});
    check("t4_le",  {39'd0, length_error}, 40'd1);
    end_pkt();
    check("t4_le_off", {39'd0, length_error}, 40'd0);

    // 5: truncated packet, a beat during the drop is discarded
    start_pkt(6'h2B, 16'd20);
    beat({8'h44, 8'h33, 8'h22, 8'h11});
    beat({8'h88, 8'h77, 8'h66, 8'hFF});
    check("t5_pe",  {39'd0, pixel_enable}, 40'd1);
    check("t5_pix", pixel, {10'h113, 10'h0CF, 10'h08B, 10'h047});
    check("t5_le0", {39'd0, length_error}, 40'd0);
    interrupt = 1'b0;
    image_data = {8'h99, 8'h99, 8'h99, 8'h99};
    image_data_enable = 1'b1;
    tick();
    check("t5_le",    {39'd0, length_error}, 40'd1);
    check("t5_pe_dr", {39'd0, pixel_enable}, 40'd0);
    image_data_enable = 1'b0;
    tick();
    check("t5_le_off", {39'd0, length_error}, 40'd0);
    start_pkt(6'h2B, 16'd5);
    beat({8'hD3, 8'hC2, 8'hB1, 8'hA0});
    check("t5n_pe_b1", {39'd0, pixel_enable}, 40'd0);
    beat({8'h00, 8'h00, 8'h00, 8'h1B});
    check("t5n_pe",  {39'd0, pixel_enable}, 40'd1);
    check("t5n_pix", pixel, {10'h34C, 10'h309, 10'h2C6, 10'h283});
    end_pkt();

    // 6: reset in mid-packet, rest of that packet skipped silently
    start_pkt(6'h2B, 16'd20);
    beat({8'h03, 8'h02, 8'h01, 8'h00});
    reset = 1'b1;
    beat({8'h07, 8'h06, 8'h05, 8'h04});
    check("t6_rst_pix", pixel, 40'd0);
    check("t6_rst_pe",  {39'd0, pixel_enable}, 40'd0);
    check("t6_rst_le",  {39'd0, length_error}, 40'd0);
    reset = 1'b0;
    beat({8'h0B, 8'h0A, 8'h09, 8'h08});
    check("t6_pe_b3", {39'd0, pixel_enable}, 40'd0);
    beat({8'h0F, 8'h0E, 8'h0D, 8'h0C});
    check("t6_pe_b4", {39'd0, pixel_enable}, 40'd0);
    beat({8'h13, 8'h12, 8'h11, 8'h10});
    check("t6_pe_b5", {39'd0, pixel_enable}, 40'd0);
    end_pkt();
    check("t6_le_end", {39'd0, length_error}, 40'd0);
    check("t6_pix_hold", pixel, 40'd0);
    start_pkt(6'h2B, 16'd5);
    beat({8'h78, 8'h56, 8'h34, 8'h12});
    beat({8'hAA, 8'hBB, 8'hCC, 8'hE4});
    check("t6n_pe",  {39'd0, pixel_enable}, 40'd1);
    check("t6n_pix", pixel, {10'h1E3, 10'h15A, 10'h0D1, 10'h048});
    check("t6n_le",  {39'd0, length_error}, 40'd0);
    end_pkt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
